// File: rtl/regex_instr_cache.sv
// regex_instr_cache: direct-mapped, read-only instruction cache, one word per line, one
// outstanding miss at a time. Sits between the regex CPU fetch port and the shared
// instruction memory.
//
// Ports:
//   clk, rst           clock; synchronous active-low reset
//   cpu_valid/addr     fetch request (held until cpu_ready)
//   cpu_ready/data     one-cycle response strobe and fetched word (cpu_data holds afterwards)
//   mem_valid/addr     miss request to backing memory (transfer on mem_valid && mem_ready)
//   mem_ready          backing memory accepts the request
//   mem_data/valid     refill word and its strobe (only honoured while waiting for a refill)
//   invalidate         flush all lines; deferred to the next idle cycle if a fetch is active
//   busy               high whenever the controller is not idle
//
// Optional feature: define REGEX_ICACHE_STATS_EN to add saturating hit_count/miss_count
// outputs, cleared by reset and by an applied flush.
module regex_instr_cache #(
  parameter int unsigned MEMORY_WIDTH      = 16,
  parameter int unsigned MEMORY_ADDR_WIDTH = 11,
  parameter int unsigned CACHE_INDEX_BITS  = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         cpu_valid,
  input  logic [MEMORY_ADDR_WIDTH-1:0] cpu_addr,
  output logic                         cpu_ready,
  output logic [MEMORY_WIDTH-1:0]      cpu_data,
  output logic                         mem_valid,
  output logic [MEMORY_ADDR_WIDTH-1:0] mem_addr,
  input  logic                         mem_ready,
  input  logic [MEMORY_WIDTH-1:0]      mem_data,
  input  logic                         mem_data_valid,
  input  logic                         invalidate,
  output logic                         busy
`ifdef REGEX_ICACHE_STATS_EN
  ,
  output logic [31:0]                  hit_count,
  output logic [31:0]                  miss_count
`endif
);

  localparam int unsigned Lines = 2 ** CACHE_INDEX_BITS;
  localparam int unsigned TagW  = MEMORY_ADDR_WIDTH - CACHE_INDEX_BITS;

  typedef enum logic [2:0] {
    StIdle,
    StLookup,
    StMissReq,
    StMissWait,
    StRespond
  } state_e;

  state_e                       state_q, state_d;
  logic [MEMORY_ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [Lines-1:0]             valid_q, valid_d;
  logic                         flush_pend_q, flush_pend_d;
  logic [MEMORY_WIDTH-1:0]      rdata_q, rdata_d;

  // Tag/data storage needs no reset: valid_q gates every use.
  logic [TagW-1:0]              tag_arr [Lines];
  logic [MEMORY_WIDTH-1:0]      data_arr [Lines];

  logic [CACHE_INDEX_BITS-1:0]  idx;
  logic [TagW-1:0]              tag;
  logic                         hit;
  logic                         refill_we;
  logic                         flush_apply;
  logic                         lookup_hit;
  logic                         lookup_miss;

  assign idx = addr_q[CACHE_INDEX_BITS-1:0];
  assign tag = addr_q[MEMORY_ADDR_WIDTH-1:CACHE_INDEX_BITS];
  assign hit = valid_q[idx] && (tag_arr[idx] == tag);

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    valid_d      = valid_q;
    flush_pend_d = flush_pend_q;
    rdata_d      = rdata_q;
    refill_we    = 1'b0;
    flush_apply  = 1'b0;
    lookup_hit   = 1'b0;
    lookup_miss  = 1'b0;

    // A flush requested mid-fetch waits for idle so the in-flight refill lands first.
    if (state_q != StIdle && invalidate) begin
      flush_pend_d = 1'b1;
    end

    unique case (state_q)
      StIdle: begin
        if (flush_pend_q || invalidate) begin
          flush_apply  = 1'b1;
          valid_d      = '0;
          flush_pend_d = 1'b0;
        end else if (cpu_valid) begin
          addr_d  = cpu_addr;
          state_d = StLookup;
        end
      end
      StLookup: begin
        if (hit) begin
          lookup_hit = 1'b1;
          rdata_d    = data_arr[idx];
          state_d    = StRespond;
        end else begin
          lookup_miss = 1'b1;
          state_d     = StMissReq;
        end
      end
      StMissReq: begin
        if (mem_ready) begin
          state_d = StMissWait;
        end
      end
      StMissWait: begin
        if (mem_data_valid) begin
          refill_we    = 1'b1;
          valid_d[idx] = 1'b1;
          rdata_d      = mem_data;
          state_d      = StRespond;
        end
      end
      StRespond: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= StIdle;
      addr_q       <= '0;
      valid_q      <= '0;
      flush_pend_q <= 1'b0;
      rdata_q      <= '0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      valid_q      <= valid_d;
      flush_pend_q <= flush_pend_d;
      rdata_q      <= rdata_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst && refill_we) begin
      tag_arr[idx]  <= tag;
      data_arr[idx] <= mem_data;
    end
  end

  assign cpu_ready = (state_q == StRespond);
  assign cpu_data  = rdata_q;
  assign mem_valid = (state_q == StMissReq);
  assign mem_addr  = addr_q;
  assign busy      = (state_q != StIdle);

`ifdef REGEX_ICACHE_STATS_EN
  logic [31:0] hit_cnt_q, hit_cnt_d;
  logic [31:0] miss_cnt_q, miss_cnt_d;

  always_comb begin
    hit_cnt_d  = hit_cnt_q;
    miss_cnt_d = miss_cnt_q;
    if (flush_apply) begin
      hit_cnt_d  = '0;
      miss_cnt_d = '0;
    end else begin
      if (lookup_hit && hit_cnt_q != '1) begin
        hit_cnt_d = hit_cnt_q + 32'd1;
      end
      if (lookup_miss && miss_cnt_q != '1) begin
        miss_cnt_d = miss_cnt_q + 32'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
    end
  end

  assign hit_count  = hit_cnt_q;
  assign miss_count = miss_cnt_q;
`endif

endmodule
